// File: rtl/lfsr_pkg.sv
// Shared constants and state type for the 10-bit XNOR LFSR (taps 9,6) stream checker.
// Optional LOST->SEED resynchronisation is enabled in the checker by LFSR_CHK_RESYNC_EN.
`timescale 1ns/1ps
package lfsr_pkg;
   localparam int LFSR_W = 10;
   localparam int TAP_A  = 9;
   localparam int TAP_B  = 6;
   localparam logic [LFSR_W-1:0] LOCKUP = 10'h3FF;

   typedef enum logic [1:0] {
      SEED  = 2'd0,
      CHECK = 2'd1,
      LOST  = 2'd2
   } chk_state_t;

   // Bit the generator would emit next, given the last LFSR_W received bits.
   function automatic logic lfsr_next_bit(input logic [LFSR_W-1:0] h);
      return ~(h[TAP_A] ^ h[TAP_B]);
   endfunction
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
`timescale 1ns/1ps
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != {W{1'b1}})) begin
         q <= q + W'(1);
      end
   end
endmodule

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising checker for the 10-bit XNOR LFSR stream; counts mismatches and flags loss of lock.
// Define LFSR_CHK_RESYNC_EN to make LOST fall back to SEED instead of being terminal.
`timescale 1ns/1ps
module lfsr_seq_checker
   import lfsr_pkg::*;
#(
   parameter int CNT_W       = 8,
   parameter int LOSS_THRESH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             clear_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic             lost
);
   chk_state_t        state, state_nxt;
   logic [LFSR_W-1:0] hist, hist_nxt;
   logic [3:0]        seed_cnt, seed_cnt_nxt;
   logic [3:0]        miss_run, miss_run_nxt;
   logic              expected;
   logic              mismatch;
   logic              err_inc;
   logic              lost_set;

   always_comb begin
      hist_nxt     = in_valid ? {hist[LFSR_W-2:0], in_bit} : hist;
      expected     = lfsr_next_bit(hist);
      mismatch     = in_valid && (in_bit != expected);
      state_nxt    = state;
      seed_cnt_nxt = seed_cnt;
      miss_run_nxt = miss_run;
      err_inc      = 1'b0;
      lost_set     = 1'b0;
      case (state)
         SEED: begin
            if (in_valid) begin
               if (seed_cnt == 4'd9) begin
                  // A full window of ones is the XNOR lock-up state; keep seeding.
                  seed_cnt_nxt = 4'd0;
                  if (hist_nxt != LOCKUP) begin
                     state_nxt = CHECK;
                  end
               end else begin
                  seed_cnt_nxt = seed_cnt + 4'd1;
               end
            end
         end
         CHECK: begin
            if (mismatch) begin
               err_inc      = 1'b1;
               miss_run_nxt = miss_run + 4'd1;
               if ((miss_run + 4'd1) == 4'(LOSS_THRESH)) begin
                  state_nxt = LOST;
                  lost_set  = 1'b1;
               end
            end else if (in_valid) begin
               miss_run_nxt = 4'd0;
            end
         end
         LOST: begin
`ifdef LFSR_CHK_RESYNC_EN
            state_nxt    = SEED;
            seed_cnt_nxt = 4'd0;
            miss_run_nxt = 4'd0;
`else
            state_nxt    = LOST;
`endif
         end
         default: state_nxt = SEED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= SEED;
         hist      <= '0;
         seed_cnt  <= 4'd0;
         miss_run  <= 4'd0;
         err_pulse <= 1'b0;
         lost      <= 1'b0;
      end else begin
         state     <= state_nxt;
         hist      <= hist_nxt;
         seed_cnt  <= seed_cnt_nxt;
         miss_run  <= miss_run_nxt;
         err_pulse <= err_inc;
         lost      <= clear_cnt ? 1'b0 : (lost | lost_set);
      end
   end

   assign locked = (state == CHECK);

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (err_inc),
      .clr   (clear_cnt),
      .q     (err_count)
   );
endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Scoreboard bench for lfsr_seq_checker: a behavioural model predicts outputs per cycle, a monitor compares.
// Honours LFSR_CHK_RESYNC_EN the same way the design does.
`timescale 1ns/1ps
module tb_lfsr_seq_checker;
   localparam int LOSS = 4;
   localparam int M_SEED  = 0;
   localparam int M_TRACK = 1;
   localparam int M_DROP  = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_bit = 1'b0;
   logic       clear_cnt = 1'b0;
   logic       locked;
   logic       err_pulse;
   logic [7:0] err_count;
   logic       lost;

   typedef struct {
      logic       locked;
      logic       err_pulse;
      logic [7:0] err_count;
      logic       lost;
   } exp_t;

   exp_t expq[$];
   int   checks = 0;
   int   errors = 0;

   bit   recent[$];
   int   mode;
   int   seedBeats;
   int   missRun;
   int   errTotal;
   bit   lostFlag;
   bit   mPulse;
   bit   genHist[$];

   always #5 clk = ~clk;

   lfsr_seq_checker #(.CNT_W(8), .LOSS_THRESH(LOSS)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .clear_cnt (clear_cnt),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count),
      .lost      (lost)
   );

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Generator: s[n] = xnor(s[n-10], s[n-7]) starting from an all-zero history.
   task automatic genNext(output bit b);
      b = !(genHist[0] ^ genHist[3]);
      genHist.push_back(b);
      void'(genHist.pop_front());
   endtask

   task automatic genReset();
      genHist = {};
      for (int i = 0; i < 10; i++) genHist.push_back(1'b0);
   endtask

   task automatic modelStep(input bit rst, input bit v, input bit b, input bit clr);
      bit predicted;
      bit allOnes;
      int startMode;
      if (rst) begin
         recent = {};
         for (int i = 0; i < 10; i++) recent.push_back(1'b0);
         mode = M_SEED; seedBeats = 0; missRun = 0; errTotal = 0; lostFlag = 0; mPulse = 0;
         return;
      end
      startMode = mode;
      mPulse = 0;
      if (v) begin
         predicted = !(recent[0] ^ recent[3]);
         recent.push_back(b);
         void'(recent.pop_front());
         if (startMode == M_SEED) begin
            seedBeats++;
            if (seedBeats == 10) begin
               seedBeats = 0;
               allOnes = 1;
               foreach (recent[i]) if (!recent[i]) allOnes = 0;
               if (!allOnes) mode = M_TRACK;
            end
         end else if (startMode == M_TRACK) begin
            if (b != predicted) begin
               mPulse = 1;
               if (errTotal < 255) errTotal++;
               missRun++;
               if (missRun == LOSS) begin
                  mode = M_DROP;
                  lostFlag = 1;
               end
            end else begin
               missRun = 0;
            end
         end
      end
`ifdef LFSR_CHK_RESYNC_EN
      if (startMode == M_DROP) begin
         mode = M_SEED; seedBeats = 0; missRun = 0;
      end
`endif
      if (clr) begin
         errTotal = 0;
         lostFlag = 0;
      end
   endtask

   task automatic applyStimulus(input bit rst, input bit v, input bit b, input bit clr);
      exp_t e;
      @(negedge clk);
      reset = rst; in_valid = v; in_bit = b; clear_cnt = clr;
      modelStep(rst, v, b, clr);
      e.locked    = (mode == M_TRACK);
      e.err_pulse = mPulse;
      e.err_count = 8'(errTotal);
      e.lost      = lostFlag;
      expq.push_back(e);
   endtask

   task automatic sendBeat(input bit inv, input bit clr);
      bit b;
      if ($urandom_range(0, 3) == 0) applyStimulus(0, 0, 1'($urandom), 0);
      genNext(b);
      applyStimulus(0, 1, b ^ inv, clr);
   endtask

   task automatic doReset();
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 1, 1'($urandom), 1);
      genReset();
   endtask

   task automatic lockUp();
      doReset();
      repeat (10) sendBeat(0, 0);
   endtask

   // One idle cycle, then sample after the following edge for directed checks.
   task automatic settle();
      applyStimulus(0, 0, 0, 0);
      @(posedge clk);
      #2;
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         checkOutput("locked", 8'(locked), 8'(e.locked));
         checkOutput("err_pulse", 8'(err_pulse), 8'(e.err_pulse));
         checkOutput("err_count", err_count, e.err_count);
         checkOutput("lost", 8'(lost), 8'(e.lost));
      end
   end

   initial begin
      doReset();
      settle();
      checkOutput("reset_locked", 8'(locked), 8'd0);
      checkOutput("reset_count", err_count, 8'd0);

      $display("[TB] clean stream lock and long run");
      repeat (10) sendBeat(0, 0);
      settle();
      checkOutput("t1_locked", 8'(locked), 8'd1);
      repeat (1023) sendBeat(0, 0);
      settle();
      checkOutput("t1_count", err_count, 8'd0);

      $display("[TB] single corrupted beat");
      lockUp();
      repeat (19) sendBeat(0, 0);
      sendBeat(1, 0);
      repeat (15) sendBeat(0, 0);
      settle();
      checkOutput("t2_count", err_count, 8'd3);
      checkOutput("t2_locked", 8'(locked), 8'd1);

      $display("[TB] lock-up pattern never locks");
      doReset();
      repeat (20) applyStimulus(0, 1, 1, 0);
      settle();
      checkOutput("t3_locked", 8'(locked), 8'd0);

      $display("[TB] inverted stream loses lock");
      lockUp();
      repeat (4) sendBeat(1, 0);
      settle();
      checkOutput("t4_lost", 8'(lost), 8'd1);
      checkOutput("t4_count", err_count, 8'd4);
      checkOutput("t4_locked", 8'(locked), 8'd0);
      repeat (12) sendBeat(0, 0);
      settle();
`ifdef LFSR_CHK_RESYNC_EN
      checkOutput("t4_relock", 8'(locked), 8'd1);
`else
      checkOutput("t4_terminal", 8'(locked), 8'd0);
`endif
      checkOutput("t4_sticky", 8'(lost), 8'd1);

      $display("[TB] clear on a mismatch beat");
      lockUp();
      sendBeat(1, 0);
      repeat (19) sendBeat(0, 0);
      sendBeat(1, 0);
      repeat (9) sendBeat(0, 0);
      sendBeat(0, 1);
      settle();
      checkOutput("t5_count", err_count, 8'd0);

      $display("[TB] idle gap and mid-check reset");
      repeat (7) applyStimulus(0, 0, 1'($urandom), 0);
      repeat (20) sendBeat(0, 0);
      sendBeat(1, 0);
      repeat (3) sendBeat(0, 0);
      applyStimulus(1, 1, 1'($urandom), 1);
      genReset();
      @(posedge clk);
      #2;
      checkOutput("t6_locked", 8'(locked), 8'd0);
      checkOutput("t6_count", err_count, 8'd0);

      $display("[TB] randomized corruption and clears");
      lockUp();
      for (int i = 0; i < 400; i++) begin
         sendBeat(($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0));
      end
      settle();
      repeat (2) @(posedge clk);
      #2;
      checkOutput("queue_drained", 8'(expq.size()), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
